// File: rtl/demod_cal_ctrl.sv
// Offset calibration controller for the demodulator: mutes the signal path, lets it
// settle, averages 2**LOG2_N mixer samples per channel and writes the means as offsets.
`timescale 1ns/1ps
module demod_cal_ctrl #(
    parameter int SETTLE_CYC  = 1024,
    parameter int LOG2_N      = 10,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic               clk_100,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic signed [15:0] mix_sin,
    input  logic signed [15:0] mix_cos,
    input  logic               mix_valid,
    input  logic               shift_wr,
    input  logic signed [15:0] shift_wsin,
    input  logic signed [15:0] shift_wcos,
    output logic               cal_mute,
    output logic signed [15:0] shiftsin,
    output logic signed [15:0] shiftcos,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int AW = 16 + LOG2_N;
    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_ACCUM, ST_APPLY} state_e;

    state_e                   state_q, state_d;
    logic [SW-1:0]            settle_cnt_q, settle_cnt_d;
    logic [LOG2_N-1:0]        samp_cnt_q, samp_cnt_d;
    logic [TW-1:0]            idle_cnt_q, idle_cnt_d;
    logic signed [AW-1:0]     acc_sin_q, acc_sin_d;
    logic signed [AW-1:0]     acc_cos_q, acc_cos_d;
    logic signed [15:0]       shiftsin_q, shiftsin_d;
    logic signed [15:0]       shiftcos_q, shiftcos_d;
    logic                     cal_mute_q, cal_mute_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     err_q, err_d;

    always_comb begin
        // NOTE: every _d gets a default before the case so no path can infer a latch.
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        samp_cnt_d   = samp_cnt_q;
        idle_cnt_d   = idle_cnt_q;
        acc_sin_d    = acc_sin_q;
        acc_cos_d    = acc_cos_q;
        shiftsin_d   = shiftsin_q;
        shiftcos_d   = shiftcos_q;
        done_d       = 1'b0;
        err_d        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (shift_wr) begin
                    shiftsin_d = shift_wsin;
                    shiftcos_d = shift_wcos;
                end
                if (start && !abort) begin
                    state_d      = ST_SETTLE;
                    settle_cnt_d = '0;
                    samp_cnt_d   = '0;
                    idle_cnt_d   = '0;
                    acc_sin_d    = '0;
                    acc_cos_d    = '0;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_q == SW'(SETTLE_CYC - 1)) state_d = ST_ACCUM;
                else settle_cnt_d = settle_cnt_q + 1'b1;
            end
            ST_ACCUM: begin
                if (mix_valid) begin
                    acc_sin_d  = acc_sin_q + $signed({{LOG2_N{mix_sin[15]}}, mix_sin});
                    acc_cos_d  = acc_cos_q + $signed({{LOG2_N{mix_cos[15]}}, mix_cos});
                    idle_cnt_d = '0;
                    if (samp_cnt_q == '1) state_d = ST_APPLY;
                    else samp_cnt_d = samp_cnt_q + 1'b1;
                end else if (idle_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
            end
            ST_APPLY: begin
                // Taking bits above LOG2_N is the arithmetic shift: floor of the mean.
                shiftsin_d = acc_sin_q[LOG2_N +: 16];
                shiftcos_d = acc_cos_q[LOG2_N +: 16];
                done_d     = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort wins over everything, including the offset update in APPLY.
        if (abort && state_q != ST_IDLE) begin
            state_d    = ST_IDLE;
            shiftsin_d = shiftsin_q;
            shiftcos_d = shiftcos_q;
            done_d     = 1'b0;
            err_d      = 1'b0;
        end

        busy_d     = (state_d != ST_IDLE);
        cal_mute_d = (state_d == ST_SETTLE) || (state_d == ST_ACCUM);
    end

    // NOTE: sequential state uses non-blocking assignments only; all logic lives above.
    always_ff @(posedge clk_100 or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            settle_cnt_q <= '0;
            samp_cnt_q   <= '0;
            idle_cnt_q   <= '0;
            acc_sin_q    <= '0;
            acc_cos_q    <= '0;
            shiftsin_q   <= '0;
            shiftcos_q   <= '0;
            cal_mute_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            samp_cnt_q   <= samp_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
            acc_sin_q    <= acc_sin_d;
            acc_cos_q    <= acc_cos_d;
            shiftsin_q   <= shiftsin_d;
            shiftcos_q   <= shiftcos_d;
            cal_mute_q   <= cal_mute_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign cal_mute = cal_mute_q;
    assign shiftsin = shiftsin_q;
    assign shiftcos = shiftcos_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_demod_cal_ctrl.sv
// Self-checking bench for demod_cal_ctrl: table of calibration vectors with a
// scoreboard of expected averages, plus hand sequences for timeout, abort and reset.
`timescale 1ns/1ps
module tb_demod_cal_ctrl;

    localparam int S = 4;
    localparam int L = 2;
    localparam int N = 4;
    localparam int T = 8;

    logic               clk_100 = 1'b0;
    logic               reset;
    logic               start, abort, mix_valid, shift_wr;
    logic signed [15:0] mix_sin, mix_cos, shift_wsin, shift_wcos;
    logic               cal_mute, busy, done, err;
    logic signed [15:0] shiftsin, shiftcos;

    demod_cal_ctrl #(.SETTLE_CYC(S), .LOG2_N(L), .TIMEOUT_CYC(T)) dut (
        .clk_100(clk_100), .reset(reset), .start(start), .abort(abort),
        .mix_sin(mix_sin), .mix_cos(mix_cos), .mix_valid(mix_valid),
        .shift_wr(shift_wr), .shift_wsin(shift_wsin), .shift_wcos(shift_wcos),
        .cal_mute(cal_mute), .shiftsin(shiftsin), .shiftcos(shiftcos),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk_100 = ~clk_100;

    typedef struct {
        logic [3:0][15:0]   s;
        logic [3:0][15:0]   c;
        bit                 alt;
        bit                 wr;
        logic signed [15:0] exp_s;
        logic signed [15:0] exp_c;
        int                 exp_lat;
        int                 exp_mute;
    } vec_t;

    typedef struct {
        logic signed [15:0] s;
        logic signed [15:0] c;
    } exp_t;

    exp_t sb_q[$];
    vec_t tbl[5];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk_100);
        #1;
    endtask

    function automatic vec_t mk(input int s0, input int s1, input int s2, input int s3,
                                input int c0, input int c1, input int c2, input int c3,
                                input bit alt, input bit wr, input int es, input int ec,
                                input int lat, input int mute);
        vec_t v;
        v.s[0] = 16'(s0); v.s[1] = 16'(s1); v.s[2] = 16'(s2); v.s[3] = 16'(s3);
        v.c[0] = 16'(c0); v.c[1] = 16'(c1); v.c[2] = 16'(c2); v.c[3] = 16'(c3);
        v.alt = alt; v.wr = wr;
        v.exp_s = 16'(es); v.exp_c = 16'(ec);
        v.exp_lat = lat; v.exp_mute = mute;
        return v;
    endfunction

    task automatic run_cal(input vec_t v);
        int   k;
        int   lat;
        int   mute_cnt;
        exp_t e;
        start = 1'b1; abort = 1'b0; shift_wr = v.wr;
        shift_wsin = 16'sd7; shift_wcos = -16'sd8;
        mix_valid = 1'b1; mix_sin = 16'sd999; mix_cos = -16'sd999;
        sb_q.push_back('{v.exp_s, v.exp_c});
        step();
        start = 1'b0; shift_wr = 1'b0;
        if (v.wr) begin
            check("wr_with_start_sin", shiftsin, 7);
            check("wr_with_start_cos", shiftcos, -8);
        end
        check("busy_after_start", busy, 1);
        mute_cnt = cal_mute ? 1 : 0;
        k = 0;
        lat = 0;
        for (int ed = 1; ed <= 60; ed++) begin
            start = (ed == 2);
            if (ed <= S) begin
                mix_valid = 1'b1; mix_sin = 16'sd1234; mix_cos = 16'sd4321;
            end else if (k < N && (!v.alt || ((ed - S) % 2 == 0))) begin
                mix_valid = 1'b1; mix_sin = v.s[k]; mix_cos = v.c[k];
                k++;
            end else begin
                mix_valid = 1'b0; mix_sin = 16'sd3333; mix_cos = -16'sd3333;
            end
            step();
            if (cal_mute) mute_cnt++;
            if (done) begin
                lat = ed;
                break;
            end
        end
        start = 1'b0; mix_valid = 1'b0;
        check("done_latency", lat, v.exp_lat);
        check("mute_cycles", mute_cnt, v.exp_mute);
        check("busy_at_done", busy, 0);
        if (done) begin
            if (sb_q.size() == 0) begin
                total++; bad++;
                $display("FAIL scoreboard: done with no expected entry");
            end else begin
                e = sb_q.pop_front();
                check("avg_sin", shiftsin, e.s);
                check("avg_cos", shiftcos, e.c);
            end
        end
        step();
        check("done_one_cycle", done, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  lat;
        bit  seen_done;

        tbl[0] = mk(100, 100, 100, 100, -100, -100, -100, -100, 0, 1, 100, -100, 9, 8);
        tbl[1] = mk(1, 2, 2, 2, -1, -2, -2, -2, 0, 0, 1, -2, 9, 8);
        tbl[2] = mk(10, 20, 30, 40, -3, -3, -3, -4, 1, 0, 25, -4, 13, 12);
        tbl[3] = mk(32767, 32767, 32767, 32767, -32768, -32768, -32768, -32768,
                    0, 0, 32767, -32768, 9, 8);
        tbl[4] = mk(-1, 0, 0, 0, 1, 1, 1, 0, 1, 0, -1, 0, 13, 12);

        reset = 1'b1; start = 1'b0; abort = 1'b0; mix_valid = 1'b0; shift_wr = 1'b0;
        mix_sin = '0; mix_cos = '0; shift_wsin = '0; shift_wcos = '0;
        step(); step();
        check("rst_busy", busy, 0);
        check("rst_mute", cal_mute, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_sin", shiftsin, 0);
        check("rst_cos", shiftcos, 0);
        reset = 1'b0;
        step();

        // Manual load in IDLE.
        shift_wr = 1'b1; shift_wsin = 16'sd55; shift_wcos = -16'sd7;
        step();
        shift_wr = 1'b0;
        check("manual_sin", shiftsin, 55);
        check("manual_cos", shiftcos, -7);

        // Timeout in ACCUM; a shift_wr while busy must not land.
        start = 1'b1;
        step();
        start = 1'b0; mix_valid = 1'b0;
        lat = 0; seen_done = 1'b0;
        for (int ed = 1; ed <= 40; ed++) begin
            shift_wr = (ed == 2); shift_wsin = 16'sd1; shift_wcos = 16'sd1;
            step();
            if (done) seen_done = 1'b1;
            if (err) begin
                lat = ed;
                break;
            end
        end
        shift_wr = 1'b0;
        check("timeout_edge", lat, S + T);
        check("timeout_busy", busy, 0);
        check("timeout_mute", cal_mute, 0);
        check("timeout_no_done", seen_done, 0);
        check("timeout_keep_sin", shiftsin, 55);
        check("timeout_keep_cos", shiftcos, -7);
        step();
        check("err_one_cycle", err, 0);

        // Start and abort together in IDLE stays idle.
        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        check("start_abort_idle", busy, 0);
        step();
        check("start_abort_idle2", cal_mute, 0);

        // Abort in ACCUM after two samples.
        start = 1'b1;
        step();
        start = 1'b0; mix_valid = 1'b1; mix_sin = 16'sd500; mix_cos = 16'sd500;
        for (int ed = 1; ed <= S + 2; ed++) step();
        check("accum_muted", cal_mute, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_mute", cal_mute, 0);
        check("abort_done", done, 0);
        check("abort_err", err, 0);
        check("abort_keep_sin", shiftsin, 55);
        seen_done = 1'b0;
        for (int ed = 0; ed < 10; ed++) begin
            step();
            if (done || err) seen_done = 1'b1;
        end
        check("abort_no_late_pulse", seen_done, 0);
        mix_valid = 1'b0;

        // Reset in the middle of a second calibration.
        start = 1'b1;
        step();
        start = 1'b0; mix_valid = 1'b1; mix_sin = 16'sd200; mix_cos = 16'sd200;
        for (int ed = 1; ed <= S + 1; ed++) step();
        reset = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_mute", cal_mute, 0);
        check("midrst_done", done, 0);
        check("midrst_err", err, 0);
        check("midrst_sin", shiftsin, 0);
        check("midrst_cos", shiftcos, 0);
        step();
        reset = 1'b0; mix_valid = 1'b0;
        step();

        for (int i = 0; i < 5; i++) begin
            run_cal(tbl[i]);
            step();
        end
        check("scoreboard_drained", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
